// File: rtl/pattern_hunt_ctrl.sv
// Run-control wrapper for a serial pattern detector: holds the hunt configuration,
// shifts the serial stream, counts matches and ends each hunt with done, timeout or abort.
module pattern_hunt_ctrl #(
  parameter int unsigned PAT_W = 4,
  parameter int unsigned CNT_W = 8,
  parameter int unsigned TMO_W = 12
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cfg_valid,
  input  logic [PAT_W-1:0] cfg_pattern,
  input  logic [CNT_W-1:0] cfg_target,
  input  logic [TMO_W-1:0] cfg_timeout,
  output logic             cfg_ready,
  input  logic             start,
  input  logic             abort,
  input  logic             A,
  input  logic             A_valid,
  output logic             Y,
  output logic [CNT_W-1:0] match_cnt,
  output logic             busy,
  output logic             done,
  output logic             timeout
);

  localparam int unsigned FILL_W = $clog2(PAT_W + 1);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_ARMED = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [PAT_W-1:0] sr_q, sr_d;
  logic [FILL_W-1:0] fill_q, fill_d;
  logic [CNT_W-1:0] match_cnt_q, match_cnt_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic [PAT_W-1:0] pat_q, pat_d;
  logic [CNT_W-1:0] tgt_q, tgt_d;
  logic [TMO_W-1:0] tmo_lim_q, tmo_lim_d;
  logic             y_q, y_d;
  logic             done_q, done_d;
  logic             timeout_q, timeout_d;
  logic             busy_q, busy_d;
  logic             cfg_ready_q, cfg_ready_d;

  logic [PAT_W-1:0]  sr_shift;
  logic [FILL_W-1:0] fill_nxt;
  logic [CNT_W-1:0]  match_inc;
  logic [CNT_W-1:0]  tgt_eff;
  logic              hit;
  logic              final_hit;

  // Next-state, datapath and pulse generation
  always_comb begin
    state_d     = state_q;
    sr_d        = sr_q;
    fill_d      = fill_q;
    match_cnt_d = match_cnt_q;
    tmo_d       = tmo_q;
    pat_d       = pat_q;
    tgt_d       = tgt_q;
    tmo_lim_d   = tmo_lim_q;
    y_d         = 1'b0;
    done_d      = 1'b0;
    timeout_d   = 1'b0;
    hit         = 1'b0;
    final_hit   = 1'b0;

    sr_shift  = {sr_q[PAT_W-2:0], A};
    fill_nxt  = (fill_q == FILL_W'(PAT_W)) ? fill_q : fill_q + FILL_W'(1);
    match_inc = match_cnt_q + CNT_W'(1);
    // A zero target behaves as a single-match hunt
    tgt_eff   = (tgt_q == '0) ? CNT_W'(1) : tgt_q;

    case (state_q)
      ST_IDLE: begin
        if (cfg_valid) begin
          pat_d     = cfg_pattern;
          tgt_d     = cfg_target;
          tmo_lim_d = cfg_timeout;
        end
        if (start) begin
          state_d     = ST_ARMED;
          sr_d        = '0;
          fill_d      = '0;
          match_cnt_d = '0;
          tmo_d       = '0;
        end
      end
      ST_ARMED: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
          if (A_valid) begin
            sr_d   = sr_shift;
            fill_d = fill_nxt;
            hit    = (fill_nxt == FILL_W'(PAT_W)) && (sr_shift == pat_q);
          end
          if (hit) begin
            y_d         = 1'b1;
            match_cnt_d = match_inc;
            final_hit   = (match_inc == tgt_eff);
          end
          // A final match on the limit edge reports done, never timeout
          if (final_hit) begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end else if ((tmo_lim_q != '0) && (tmo_d == tmo_lim_q)) begin
            timeout_d = 1'b1;
            state_d   = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d      = (state_d == ST_ARMED);
    cfg_ready_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      sr_q        <= '0;
      fill_q      <= '0;
      match_cnt_q <= '0;
      tmo_q       <= '0;
      pat_q       <= '0;
      tgt_q       <= CNT_W'(1);
      tmo_lim_q   <= '0;
      y_q         <= 1'b0;
      done_q      <= 1'b0;
      timeout_q   <= 1'b0;
      busy_q      <= 1'b0;
      cfg_ready_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      sr_q        <= sr_d;
      fill_q      <= fill_d;
      match_cnt_q <= match_cnt_d;
      tmo_q       <= tmo_d;
      pat_q       <= pat_d;
      tgt_q       <= tgt_d;
      tmo_lim_q   <= tmo_lim_d;
      y_q         <= y_d;
      done_q      <= done_d;
      timeout_q   <= timeout_d;
      busy_q      <= busy_d;
      cfg_ready_q <= cfg_ready_d;
    end
  end

  assign Y         = y_q;
  assign match_cnt = match_cnt_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign timeout   = timeout_q;
  assign cfg_ready = cfg_ready_q;

endmodule

// File: tb/tb_pattern_hunt_ctrl.sv
// Directed bench for pattern_hunt_ctrl: reset, matching, overlap, timeout,
// bubbles, abort, configuration lockout and done-over-timeout priority.
module tb_pattern_hunt_ctrl;

  logic        clk;
  logic        reset;
  logic        cfg_valid;
  logic [3:0]  cfg_pattern;
  logic [7:0]  cfg_target;
  logic [11:0] cfg_timeout;
  logic        cfg_ready;
  logic        start;
  logic        abort;
  logic        A;
  logic        A_valid;
  logic        Y;
  logic [7:0]  match_cnt;
  logic        busy;
  logic        done;
  logic        timeout;

  int checks = 0;
  int errors = 0;

  pattern_hunt_ctrl #(.PAT_W(4), .CNT_W(8), .TMO_W(12)) dut (
    .clk        (clk),
    .reset      (reset),
    .cfg_valid  (cfg_valid),
    .cfg_pattern(cfg_pattern),
    .cfg_target (cfg_target),
    .cfg_timeout(cfg_timeout),
    .cfg_ready  (cfg_ready),
    .start      (start),
    .abort      (abort),
    .A          (A),
    .A_valid    (A_valid),
    .Y          (Y),
    .match_cnt  (match_cnt),
    .busy       (busy),
    .done       (done),
    .timeout    (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic b);
    A       = b;
    A_valid = 1'b1;
    tick();
    A_valid = 1'b0;
  endtask

  task automatic arm(input logic [3:0] pat, input logic [7:0] tgt, input logic [11:0] tmo);
    cfg_pattern = pat;
    cfg_target  = tgt;
    cfg_timeout = tmo;
    cfg_valid   = 1'b1;
    start       = 1'b1;
    tick();
    cfg_valid   = 1'b0;
    start       = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #2;
    checks++;
    if (busy !== 1'b0 || cfg_ready !== 1'b1 || match_cnt !== 8'd0 || Y !== 1'b0 ||
        done !== 1'b0 || timeout !== 1'b0) begin
      errors++;
      $display("FAIL reset_init: busy=%b rdy=%b cnt=%0d Y=%b done=%b tmo=%b, want 0 1 0 0 0 0",
               busy, cfg_ready, match_cnt, Y, done, timeout);
    end
    tick();
    reset = 1'b0;
    tick();
    arm(4'b1011, 8'd2, 12'd0);
    send(1); send(0); send(1); send(1);
    checks++;
    if (match_cnt !== 8'd1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL reset_pre: cnt=%0d busy=%b, want 1 1", match_cnt, busy);
    end
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b0 || cfg_ready !== 1'b1 || match_cnt !== 8'd0 || Y !== 1'b0) begin
      errors++;
      $display("FAIL reset_async: busy=%b rdy=%b cnt=%0d Y=%b, want 0 1 0 0",
               busy, cfg_ready, match_cnt, Y);
    end
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    logic [9:0] bits;
    logic [9:0] expy;
    bits = 10'b1011111011;
    expy = 10'b0001000001;
    arm(4'b1011, 8'd2, 12'd0);
    for (int i = 0; i < 10; i++) begin
      send(bits[9-i]);
      checks++;
      if (Y !== expy[9-i] || done !== (i == 9)) begin
        errors++;
        $display("FAIL basic_y[%0d]: Y=%b done=%b, want %b %b", i, Y, done, expy[9-i], i == 9);
      end
    end
    checks++;
    if (match_cnt !== 8'd2 || cfg_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL basic_end: cnt=%0d rdy=%b busy=%b, want 2 1 0", match_cnt, cfg_ready, busy);
    end
    tick();
    checks++;
    if (done !== 1'b0 || Y !== 1'b0 || match_cnt !== 8'd2) begin
      errors++;
      $display("FAIL basic_hold: done=%b Y=%b cnt=%0d, want 0 0 2", done, Y, match_cnt);
    end
  endtask

  task automatic test_overlap();
    logic [7:0] bits;
    logic [7:0] expy;
    bits = 8'b10101010;
    expy = 8'b00010101;
    arm(4'b1010, 8'd3, 12'd0);
    for (int i = 0; i < 8; i++) begin
      send(bits[7-i]);
      checks++;
      if (Y !== expy[7-i] || done !== (i == 7)) begin
        errors++;
        $display("FAIL overlap_y[%0d]: Y=%b done=%b, want %b %b", i, Y, done, expy[7-i], i == 7);
      end
    end
    checks++;
    if (match_cnt !== 8'd3) begin
      errors++;
      $display("FAIL overlap_cnt: cnt=%0d, want 3", match_cnt);
    end
  endtask

  task automatic test_timeout();
    arm(4'b1111, 8'd1, 12'd20);
    for (int i = 1; i <= 20; i++) begin
      send(0);
      checks++;
      if (timeout !== (i == 20) || busy !== (i != 20) || done !== 1'b0) begin
        errors++;
        $display("FAIL timeout_cyc[%0d]: tmo=%b busy=%b done=%b, want %b %b 0",
                 i, timeout, busy, done, i == 20, i != 20);
      end
    end
    checks++;
    if (match_cnt !== 8'd0) begin
      errors++;
      $display("FAIL timeout_cnt: cnt=%0d, want 0", match_cnt);
    end
    tick();
    checks++;
    if (timeout !== 1'b0 || cfg_ready !== 1'b1) begin
      errors++;
      $display("FAIL timeout_pulse: tmo=%b rdy=%b, want 0 1", timeout, cfg_ready);
    end
  endtask

  task automatic test_gaps_abort();
    logic [9:0] bits;
    logic [9:0] expy;
    bits = 10'b1011111011;
    expy = 10'b0001000001;
    arm(4'b1011, 8'd2, 12'd0);
    for (int i = 0; i < 10; i++) begin
      send(bits[9-i]);
      checks++;
      if (Y !== expy[9-i]) begin
        errors++;
        $display("FAIL gaps_y[%0d]: Y=%b, want %b", i, Y, expy[9-i]);
      end
      if (i % 3 == 1 && i < 9) begin
        A = ~A;
        tick();
        tick();
        checks++;
        if (Y !== 1'b0 || busy !== 1'b1) begin
          errors++;
          $display("FAIL gaps_bubble[%0d]: Y=%b busy=%b, want 0 1", i, Y, busy);
        end
      end
    end
    checks++;
    if (done !== 1'b1 || match_cnt !== 8'd2) begin
      errors++;
      $display("FAIL gaps_done: done=%b cnt=%0d, want 1 2", done, match_cnt);
    end
    arm(4'b1011, 8'd2, 12'd0);
    send(1); send(0); send(1); send(1);
    checks++;
    if (Y !== 1'b1 || match_cnt !== 8'd1) begin
      errors++;
      $display("FAIL abort_pre: Y=%b cnt=%0d, want 1 1", Y, match_cnt);
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (busy !== 1'b0 || cfg_ready !== 1'b1 || match_cnt !== 8'd1 ||
          done !== 1'b0 || timeout !== 1'b0) begin
        errors++;
        $display("FAIL abort_post[%0d]: busy=%b rdy=%b cnt=%0d done=%b tmo=%b, want 0 1 1 0 0",
                 i, busy, cfg_ready, match_cnt, done, timeout);
      end
      tick();
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checks++;
    if (cfg_ready !== 1'b1 || match_cnt !== 8'd1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL abort_idle: rdy=%b cnt=%0d busy=%b, want 1 1 0", cfg_ready, match_cnt, busy);
    end
  endtask

  task automatic test_cfg_lockout();
    arm(4'b1011, 8'd0, 12'd0);
    cfg_pattern = 4'b0000;
    cfg_target  = 8'd5;
    cfg_timeout = 12'd2;
    cfg_valid   = 1'b1;
    start       = 1'b1;
    tick();
    cfg_valid   = 1'b0;
    start       = 1'b0;
    checks++;
    if (busy !== 1'b1 || cfg_ready !== 1'b0) begin
      errors++;
      $display("FAIL lockout_armed: busy=%b rdy=%b, want 1 0", busy, cfg_ready);
    end
    send(1); send(0); send(1);
    checks++;
    if (Y !== 1'b0 || timeout !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL lockout_mid: Y=%b tmo=%b busy=%b, want 0 0 1", Y, timeout, busy);
    end
    send(1);
    checks++;
    if (Y !== 1'b1 || done !== 1'b1 || match_cnt !== 8'd1) begin
      errors++;
      $display("FAIL lockout_done: Y=%b done=%b cnt=%0d, want 1 1 1", Y, done, match_cnt);
    end
  endtask

  task automatic test_done_vs_timeout();
    arm(4'b1011, 8'd1, 12'd4);
    send(1); send(0); send(1); send(1);
    checks++;
    if (done !== 1'b1 || timeout !== 1'b0 || Y !== 1'b1) begin
      errors++;
      $display("FAIL done_wins: done=%b tmo=%b Y=%b, want 1 0 1", done, timeout, Y);
    end
    tick();
    checks++;
    if (timeout !== 1'b0 || done !== 1'b0 || cfg_ready !== 1'b1) begin
      errors++;
      $display("FAIL done_wins_after: tmo=%b done=%b rdy=%b, want 0 0 1", timeout, done, cfg_ready);
    end
  endtask

  initial begin
    cfg_valid   = 1'b0;
    cfg_pattern = '0;
    cfg_target  = '0;
    cfg_timeout = '0;
    start       = 1'b0;
    abort       = 1'b0;
    A           = 1'b0;
    A_valid     = 1'b0;
    test_reset();
    test_basic();
    test_overlap();
    test_timeout();
    test_gaps_abort();
    test_cfg_lockout();
    test_done_vs_timeout();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
